// File: rtl/mesh_arb_pkg.sv
// Shared types and the round-robin pick helper for the mesh injection arbiter.
package mesh_arb_pkg;

    typedef enum logic {S_ARB, S_HOLD} arb_state_t;

    localparam int MAX_SRC   = 32;
    localparam int SRC_IDX_W = 5;

    // First set bit strictly after ptr, wrapping at n; returns ptr if req is empty.
    function automatic logic [SRC_IDX_W-1:0] rr_next(input logic [MAX_SRC-1:0]   req,
                                                     input logic [SRC_IDX_W-1:0] ptr,
                                                     input int                   n);
        logic [SRC_IDX_W-1:0] win;
        logic                 found;
        int                   idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= MAX_SRC; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (!found && i <= n && req[idx[SRC_IDX_W-1:0]]) begin
                win   = idx[SRC_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mesh_inj_arbiter_if.sv
// Source-side valid/ready bundle plus the pending-FIFO head seen by the mesh terminal.
interface mesh_inj_arbiter_if #(
    parameter int N_SRC     = 4,
    parameter int pckg_sz   = 40,
    parameter int BUF_DEPTH = 2
);
    logic [N_SRC-1:0]                 src_valid;
    logic [N_SRC*pckg_sz-1:0]         src_data;
    logic [N_SRC-1:0]                 src_ready;
    logic                             pndng_i_in;
    logic [pckg_sz-1:0]               data_out_i_in;
    logic                             popin;
    logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count;
    logic                             pop_err;

    modport master (
        output src_valid, src_data, popin,
        input  src_ready, pndng_i_in, data_out_i_in, buf_count, pop_err
    );

    modport slave (
        input  src_valid, src_data, popin,
        output src_ready, pndng_i_in, data_out_i_in, buf_count, pop_err
    );
endinterface

// File: rtl/mesh_inj_fifo.sv
// Small in-order packet buffer; head is always presented combinationally from storage.
module mesh_inj_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 40,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          pndng
);
    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    do_push, do_pop;

    assign pndng   = (count != '0);
    assign do_pop  = pop & pndng;
    assign do_push = push & (count < CW'(DEPTH));
    assign head    = mem[rd_ptr];

    // Storage is cleared so the head reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mesh_inj_arbiter.sv
// Round-robin, burst-capable injection arbiter feeding one mesh terminal input port.
module mesh_inj_arbiter #(
    parameter int N_SRC     = 4,
    parameter int pckg_sz   = 40,
    parameter int BUF_DEPTH = 2,
    parameter int BURST     = 1
) (
    input  logic              clk,
    input  logic              reset,
    mesh_inj_arbiter_if.slave bus
);
    import mesh_arb_pkg::*;

    localparam int IW  = $clog2(N_SRC);
    localparam int CW  = $clog2(BUF_DEPTH+1);
    localparam int BCW = $clog2(BURST+1);

    arb_state_t         state;
    logic [IW-1:0]      rr_ptr, owner, win, sel;
    logic [BCW-1:0]     burst_cnt;
    logic [N_SRC-1:0]   grant;
    logic               space, push, pndng, pop_err_q;
    logic [pckg_sz-1:0] push_data;
    logic [CW-1:0]      count;

    // Space looks only at the registered count; a same-cycle pop does not free a slot.
    assign space = (count < CW'(BUF_DEPTH));
    assign win   = IW'(rr_next(MAX_SRC'(bus.src_valid), SRC_IDX_W'(rr_ptr), N_SRC));
    assign sel   = (state == S_HOLD) ? owner : win;

    always_comb begin
        grant = '0;
        if (!reset && space) begin
            if (state == S_ARB) begin
                if (|bus.src_valid) grant[win] = 1'b1;
            end else if (bus.src_valid[owner]) begin
                grant[owner] = 1'b1;
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < N_SRC; i++)
            if (IW'(i) == sel) push_data = bus.src_data[i*pckg_sz +: pckg_sz];
    end

    assign push          = |grant;
    assign bus.src_ready = grant;
    assign bus.pop_err   = pop_err_q;
    assign bus.buf_count = count;
    assign bus.pndng_i_in = pndng;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ARB;
            rr_ptr    <= IW'(N_SRC-1);
            owner     <= '0;
            burst_cnt <= '0;
            pop_err_q <= 1'b0;
        end else begin
            pop_err_q <= bus.popin & ~pndng;
            case (state)
                S_ARB: begin
                    if (push) begin
                        rr_ptr <= win;
                        if (BURST > 1) begin
                            state     <= S_HOLD;
                            owner     <= win;
                            burst_cnt <= BCW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    // Owner leaving ends the burst without a grant; a full buffer just stalls it.
                    if (!bus.src_valid[owner]) begin
                        state     <= S_ARB;
                        burst_cnt <= '0;
                    end else if (push) begin
                        if (burst_cnt == BCW'(BURST-1)) begin
                            state     <= S_ARB;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                        end
                    end
                end
                default: state <= S_ARB;
            endcase
        end
    end

    mesh_inj_fifo #(.DEPTH(BUF_DEPTH), .W(pckg_sz)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.popin),
        .head      (bus.data_out_i_in),
        .count     (count),
        .pndng     (pndng)
    );

endmodule
